one_wire_master: RTL and testbench
==================================

// Module: one_wire_master
// PURPOSE
// - Parametrised multi-channel 1-Wire bus master: reset/presence, read and write of 1..8 bits LSB-first.
// - Standard or overdrive timing per command; running Dallas CRC8 over all transferred bits.
// - Sits between a CPU/DMA command port (valid/ready) and N open-drain pads; exactly one bus is active at a time.
// PARAMETERS
// - N_CH    4   number of 1-Wire buses (>=1); CH_W = max(1,$clog2(N_CH))
// - CLK_DIV 25  clk cycles per 0.5 us timing tick (25 = 50 MHz); must be >=2
// PORTS
// - clk            in   1     system clock; single clock domain
// - rst_n          in   1     asynchronous, active-low reset
// - cmd_valid      in   1     command offered
// - cmd_ready      out  1     command accepted when valid&ready
// - cmd_op         in   2     0=RESET 1=WRITE 2=READ 3=reserved (returns err)
// - cmd_len        in   3     bits to transfer, 0 means 8; ignored for RESET
// - cmd_data       in   8     write data, LSB sent first
// - cmd_ch         in   CH_W  target bus
// - cmd_od         in   1     1 = overdrive timing
// - rsp_valid      out  1     response held until rsp_ready
// - rsp_ready      in   1     response consumed when valid&ready
// - rsp_data       out  8     read bits in [len-1:0], upper bits 0; 0 for RESET/WRITE
// - rsp_presence   out  1     RESET: device answered presence
// - rsp_err        out  1     bad channel, reserved op, or bus held low at RESET start
// - rsp_crc        out  8     CRC8 after this command
// - ow_drive_low   out  N_CH  1 = pull pad low (open drain); one-hot or zero
// - ow_in          in   N_CH  raw pad level; asynchronous
// BEHAVIOUR
// - Reset: all outputs 0, crc=0, FSM IDLE, tick prescaler 0; pads released immediately (async).
// - ow_in passes through a 2-FF synchroniser; all samples use the synchronised level.
// - Tick: prescaler pulses every CLK_DIV clks; restarted on command accept so phases are tick-aligned.
// - cmd_ready = (state==IDLE) & ~rsp_valid. Command captured in accept cycle; bus activity starts next tick.
// - Timing (ticks of 0.5 us, std/od), counters 10 bit:
//   reset low 960/140; presence sample 140/17 after release; reset high total 960/96;
//   slot total 140/20; write1/read low 12/2; write0 low 120/15; read sample 30/4 from slot start; recovery 2/2.
// - FSM: IDLE -> RST_LOW -> RST_WAIT (sample) -> RST_RECOV -> RESP;
//   IDLE -> SLOT_LOW -> SLOT_HIGH (read sample inside) -> SLOT_RECOV -> next bit or RESP; RESP -> IDLE on rsp handshake.
// - RESET: if synced ow_in[ch]==0 at accept -> err=1, no drive, RESP next cycle.
//   Otherwise presence = (sample==0); crc cleared to 0.
// - WRITE/READ: per bit crc = (crc>>1) ^ (crc[0]^bit ? 8'h8C : 0), bit = written or sampled value.
//   READ drives a write-1 slot.
// - cmd_ch >= N_CH or op==3: no bus activity, crc unchanged, err=1, RESP next cycle.
// - rsp_* stable while rsp_valid & ~rsp_ready; a new command is never accepted before the handshake.
// - ow_drive_low asserted only on captured channel; deasserted in RESP/IDLE.
// - Slave stretching is not detected; a line low at the read sample reads 0.
// - rst_n low mid-slot: pad released immediately; no response is emitted.
// STRUCTURE
// - one_wire_pkg: op_e, state_e, timing struct {rst_low, pres_smp, rst_tot, slot, low1, low0, rd_smp, rec}.
//   Also localparams T_STD and T_OD, and CRC_POLY = 8'h8C.
// - Sub-module one_wire_crc8: 1-bit serial CRC8 with clear and enable; instantiated once.
// - Top: prescaler, synchroniser, FSM, bit and tick counters, shift register, response regs.
// TESTING
// - RESET ch1 std, model pulls low 120-360 ticks after release -> ch1 low exactly 960 ticks, presence=1, err=0, crc=0.
// - RESET ch0 od, no device -> low 140 ticks, rsp_presence=0, err=0, total RESP after 236 ticks.
// - WRITE 0x33 len0 std -> 8 slots LSB first: low widths 12,12,120,120,12,12,120,120 ticks; crc matches model.
// - READ len0, model returns 0xA2 -> rsp_data=0xA2; crc over 0x33,0xA2 matches model.
// - READ len=2 od, model bits 1,0 -> rsp_data=0x01; slot 20 ticks. Then cmd_ch=N_CH -> err=1 with no pad activity.
// - Hold rsp_ready=0 for 50 cycles -> cmd_ready=0, rsp stable. Assert rst_n mid-write0 -> pad released same cycle.

Source files
------------

// File: rtl/one_wire_pkg.sv
// Shared types and timing tables for the 1-Wire master.
// Timings are in 0.5 us ticks; T_STD/T_OD select standard or overdrive speed.
package one_wire_pkg;

   typedef enum logic [1:0] {
      OP_RESET = 2'd0,
      OP_WRITE = 2'd1,
      OP_READ  = 2'd2,
      OP_RSVD  = 2'd3
   } op_e;

   typedef enum logic [2:0] {
      S_IDLE,
      S_RST_LOW,
      S_RST_WAIT,
      S_RST_RECOV,
      S_SLOT_LOW,
      S_SLOT_HIGH,
      S_SLOT_RECOV,
      S_RESP
   } state_e;

   typedef struct packed {
      logic [9:0] rst_low;
      logic [9:0] pres_smp;
      logic [9:0] rst_tot;
      logic [9:0] slot;
      logic [9:0] low1;
      logic [9:0] low0;
      logic [9:0] rd_smp;
      logic [9:0] rec;
   } timing_t;

   localparam timing_t T_STD = '{rst_low: 10'd960, pres_smp: 10'd140, rst_tot: 10'd960,
                                 slot: 10'd140, low1: 10'd12, low0: 10'd120,
                                 rd_smp: 10'd30, rec: 10'd2};
   localparam timing_t T_OD  = '{rst_low: 10'd140, pres_smp: 10'd17, rst_tot: 10'd96,
                                 slot: 10'd20, low1: 10'd2, low0: 10'd15,
                                 rd_smp: 10'd4, rec: 10'd2};

   localparam logic [7:0] CRC_POLY = 8'h8C;

endpackage

// File: rtl/one_wire_crc8.sv
// Bit-serial Dallas CRC8 (reflected poly 0x8C) with synchronous clear.
module one_wire_crc8
   import one_wire_pkg::*;
(
   input  logic       clk,
   input  logic       rst_n,
   input  logic       i_clr,
   input  logic       i_en,
   input  logic       i_bit,
   output logic [7:0] o_crc
);

   logic [7:0] r_crc;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         r_crc <= '0;
      else if (i_clr)
         r_crc <= '0;
      else if (i_en)
         r_crc <= (r_crc >> 1) ^ ((r_crc[0] ^ i_bit) ? CRC_POLY : 8'h00);
   end

   assign o_crc = r_crc;

endmodule

// File: rtl/one_wire_master.sv
// Multi-channel 1-Wire bus master: reset/presence and 1..8 bit LSB-first
// read/write slots, std/overdrive timing, running CRC8 over transferred bits.
module one_wire_master
   import one_wire_pkg::*;
#(
   parameter int N_CH    = 4,
   parameter int CLK_DIV = 25,
   localparam int CH_W   = (N_CH > 1) ? $clog2(N_CH) : 1
)(
   input  logic            clk,
   input  logic            rst_n,
   input  logic            cmd_valid,
   output logic            cmd_ready,
   input  logic [1:0]      cmd_op,
   input  logic [2:0]      cmd_len,
   input  logic [7:0]      cmd_data,
   input  logic [CH_W-1:0] cmd_ch,
   input  logic            cmd_od,
   output logic            rsp_valid,
   input  logic            rsp_ready,
   output logic [7:0]      rsp_data,
   output logic            rsp_presence,
   output logic            rsp_err,
   output logic [7:0]      rsp_crc,
   output logic [N_CH-1:0] ow_drive_low,
   input  logic [N_CH-1:0] ow_in
);

   localparam int PW = $clog2(CLK_DIV);

   logic [PW-1:0]   r_presc;
   logic [N_CH-1:0] r_sync1, r_sync2;
   state_e          r_state;
   op_e             r_op;
   logic [CH_W-1:0] r_ch;
   timing_t         r_t;
   logic [3:0]      r_len, r_idx;
   logic [7:0]      r_shift;
   logic            r_rbit;
   logic [9:0]      r_cnt;
   logic            r_drive;
   logic            r_rsp_valid, r_pres, r_err;
   logic [7:0]      r_rsp_data;

   logic            w_tick, w_accept, w_ch_ok, w_line, w_smp, w_bit;
   logic            w_crc_clr, w_crc_en;
   logic [7:0]      w_nxt_shift, w_crc;

   assign w_tick      = (r_presc == PW'(CLK_DIV - 1));
   assign cmd_ready   = (r_state == S_IDLE) & ~r_rsp_valid;
   assign w_accept    = cmd_valid & cmd_ready;
   assign w_ch_ok     = (32'(cmd_ch) < N_CH);
   assign w_line      = r_sync2[cmd_ch];
   assign w_smp       = r_sync2[r_ch];
   assign w_bit       = (r_op == OP_READ) ? r_rbit : r_shift[0];
   assign w_nxt_shift = {w_bit, r_shift[7:1]};
   // CRC updates on the same edge that retires a bit or finishes a reset, so rsp_crc is current in RESP
   assign w_crc_en    = (r_state == S_SLOT_RECOV) & w_tick & (r_cnt == r_t.rec);
   assign w_crc_clr   = (r_state == S_RST_RECOV) & w_tick & (r_cnt == r_t.rst_tot);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_presc <= '0;
         r_sync1 <= '1;
         r_sync2 <= '1;
      end else begin
         r_presc <= (w_accept || w_tick) ? '0 : r_presc + 1'b1;
         r_sync1 <= ow_in;
         r_sync2 <= r_sync1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= S_IDLE;
         r_op        <= OP_RESET;
         r_ch        <= '0;
         r_t         <= T_STD;
         r_len       <= '0;
         r_idx       <= '0;
         r_shift     <= '0;
         r_rbit      <= 1'b0;
         r_cnt       <= '0;
         r_drive     <= 1'b0;
         r_rsp_valid <= 1'b0;
         r_rsp_data  <= '0;
         r_pres      <= 1'b0;
         r_err       <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: if (w_accept) begin
               r_op       <= op_e'(cmd_op);
               r_ch       <= cmd_ch;
               r_t        <= cmd_od ? T_OD : T_STD;
               r_len      <= (cmd_len == 3'd0) ? 4'd8 : {1'b0, cmd_len};
               r_shift    <= cmd_data;
               r_idx      <= '0;
               r_cnt      <= '0;
               r_rsp_data <= '0;
               r_pres     <= 1'b0;
               r_err      <= 1'b0;
               if (!w_ch_ok || cmd_op == OP_RSVD || (cmd_op == OP_RESET && !w_line)) begin
                  r_err       <= 1'b1;
                  r_rsp_valid <= 1'b1;
                  r_state     <= S_RESP;
               end else if (cmd_op == OP_RESET)
                  r_state <= S_RST_LOW;
               else
                  r_state <= S_SLOT_LOW;
            end
            S_RST_LOW: if (w_tick) begin
               r_cnt <= r_cnt + 10'd1;
               if (r_cnt == '0)
                  r_drive <= 1'b1;
               else if (r_cnt == r_t.rst_low) begin
                  r_drive <= 1'b0;
                  r_cnt   <= 10'd1;
                  r_state <= S_RST_WAIT;
               end
            end
            S_RST_WAIT: if (w_tick) begin
               r_cnt <= r_cnt + 10'd1;
               if (r_cnt == r_t.pres_smp) begin
                  r_pres  <= ~w_smp;
                  r_state <= S_RST_RECOV;
               end
            end
            S_RST_RECOV: if (w_tick) begin
               r_cnt <= r_cnt + 10'd1;
               if (r_cnt == r_t.rst_tot) begin
                  r_rsp_valid <= 1'b1;
                  r_state     <= S_RESP;
               end
            end
            S_SLOT_LOW: if (w_tick) begin
               r_cnt <= r_cnt + 10'd1;
               if (r_cnt == '0)
                  r_drive <= 1'b1;
               else if (r_cnt == ((r_op == OP_READ || r_shift[0]) ? r_t.low1 : r_t.low0)) begin
                  r_drive <= 1'b0;
                  r_state <= S_SLOT_HIGH;
               end
            end
            S_SLOT_HIGH: if (w_tick) begin
               r_cnt <= r_cnt + 10'd1;
               if (r_op == OP_READ && r_cnt == r_t.rd_smp)
                  r_rbit <= w_smp;
               if (r_cnt == r_t.slot) begin
                  r_cnt   <= 10'd1;
                  r_state <= S_SLOT_RECOV;
               end
            end
            S_SLOT_RECOV: if (w_tick) begin
               r_cnt <= r_cnt + 10'd1;
               if (r_cnt == r_t.rec) begin
                  r_shift <= w_nxt_shift;
                  r_idx   <= r_idx + 4'd1;
                  if (r_idx + 4'd1 == r_len) begin
                     r_rsp_valid <= 1'b1;
                     r_state     <= S_RESP;
                     if (r_op == OP_READ)
                        r_rsp_data <= w_nxt_shift >> (4'd8 - r_len);
                  end else begin
                     // recovery end doubles as the next slot's start tick
                     r_drive <= 1'b1;
                     r_cnt   <= 10'd1;
                     r_state <= S_SLOT_LOW;
                  end
               end
            end
            S_RESP: if (rsp_ready) begin
               r_rsp_valid <= 1'b0;
               r_state     <= S_IDLE;
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   one_wire_crc8 u_crc (
      .clk   (clk),
      .rst_n (rst_n),
      .i_clr (w_crc_clr),
      .i_en  (w_crc_en),
      .i_bit (w_bit),
      .o_crc (w_crc)
   );

   assign ow_drive_low = r_drive ? (N_CH'(1) << r_ch) : '0;
   assign rsp_valid    = r_rsp_valid;
   assign rsp_data     = r_rsp_data;
   assign rsp_presence = r_pres;
   assign rsp_err      = r_err;
   assign rsp_crc      = w_crc;

endmodule

// File: tb/tb_one_wire_master.sv
// Scoreboard bench for one_wire_master with a behavioural 1-Wire slave per channel.
module tb_one_wire_master;

   localparam int N_CH = 3;
   localparam int CD   = 2;

   // per-speed timing in ticks, index 0 = standard, 1 = overdrive
   int RL[2]   = '{960, 140};
   int RT[2]   = '{960, 96};
   int SL[2]   = '{140, 20};
   int LO1[2]  = '{12, 2};
   int LO0[2]  = '{120, 15};
   int REC[2]  = '{2, 2};

   logic            clk, rst_n;
   logic            cmd_valid, cmd_ready, cmd_od;
   logic [1:0]      cmd_op;
   logic [2:0]      cmd_len;
   logic [7:0]      cmd_data;
   logic [1:0]      cmd_ch;
   logic            rsp_valid, rsp_ready, rsp_presence, rsp_err;
   logic [7:0]      rsp_data, rsp_crc;
   logic [N_CH-1:0] ow_drive_low, ow_in;

   one_wire_master #(.N_CH(N_CH), .CLK_DIV(CD)) dut (
      .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
      .cmd_op(cmd_op), .cmd_len(cmd_len), .cmd_data(cmd_data), .cmd_ch(cmd_ch),
      .cmd_od(cmd_od), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
      .rsp_data(rsp_data), .rsp_presence(rsp_presence), .rsp_err(rsp_err),
      .rsp_crc(rsp_crc), .ow_drive_low(ow_drive_low), .ow_in(ow_in)
   );

   typedef struct {
      logic [7:0] data;
      bit         pres;
      bit         err;
      logic [7:0] crc;
      int         dur;
   } exp_t;
   typedef struct {
      int ch;
      int ticks;
   } pulse_t;

   exp_t       exp_q[$];
   pulse_t     pulse_q[$];
   bit         rd_q[$];
   int         rd_ch;
   bit         rd_od;
   bit         present[N_CH] = '{0, 1, 1};
   bit         stuck[N_CH]   = '{0, 0, 0};
   logic [7:0] model_crc;
   bit         hold_rdy;
   int         checks, failures, cyc;

   initial begin
      clk = 0;
      forever #5 clk = ~clk;
   end
   always @(posedge clk) cyc++;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, req, $time);
      end
   endtask

   function automatic logic [7:0] crc_step(input logic [7:0] c, input bit b);
      return (c >> 1) ^ ((c[0] ^ b) ? 8'h8C : 8'h00);
   endfunction

   task automatic wait_ready();
      int n = 0;
      while (!(cmd_ready === 1'b1) && n < 20000) begin
         @(negedge clk);
         n++;
      end
      if (n >= 20000) begin
         failures++;
         $display("FAIL ready_timeout actual=0 required=1");
      end
   endtask

   task automatic issue(input int op, input int ch, input int len, input logic [7:0] data,
                        input bit od, input logic [7:0] rdv);
      exp_t e;
      int   n = (len == 0) ? 8 : len;
      bit   b;
      wait_ready();
      e.data = '0; e.pres = 0; e.err = 0; e.dur = 0;
      if (ch >= N_CH || op == 3 || (op == 0 && stuck[ch])) begin
         e.err = 1;
      end else if (op == 0) begin
         e.pres = present[ch];
         model_crc = '0;
         e.dur = RL[od] + RT[od];
         pulse_q.push_back('{ch, RL[od]});
      end else begin
         rd_ch = ch;
         rd_od = od;
         for (int i = 0; i < n; i++) begin
            b = (op == 1) ? data[i] : rdv[i];
            model_crc = crc_step(model_crc, b);
            pulse_q.push_back('{ch, (op == 2 || b) ? LO1[od] : LO0[od]});
            if (op == 2) begin
               rd_q.push_back(b);
               e.data[i] = b;
            end
         end
         e.dur = n * (SL[od] + REC[od]);
      end
      e.crc = model_crc;
      exp_q.push_back(e);
      @(posedge clk); #1;
      cmd_valid = 1; cmd_op = 2'(op); cmd_ch = 2'(ch); cmd_len = 3'(len);
      cmd_data = data; cmd_od = od;
      @(posedge clk); #1;
      cmd_valid = 0;
   endtask

   // response ready: random back-pressure unless held
   initial begin
      rsp_ready = 0;
      forever begin
         @(posedge clk); #1;
         rsp_ready = hold_rdy ? 1'b0 : ($urandom_range(0, 3) != 0);
      end
   end

   // behavioural slave: presence after long low pulses, pulls low for read 0 bits
   initial begin
      int  low_len[N_CH], since_rel[N_CH], pull_cnt;
      bit  prev[N_CH], rst_od[N_CH], drv, pp;
      pull_cnt = 0;
      for (int c = 0; c < N_CH; c++) begin
         low_len[c] = 0; since_rel[c] = -1; prev[c] = 0; rst_od[c] = 0;
      end
      ow_in = '1;
      forever begin
         @(negedge clk);
         for (int c = 0; c < N_CH; c++) begin
            drv = ow_drive_low[c];
            if (drv && !prev[c]) begin
               low_len[c] = 0;
               if (c == rd_ch && rd_q.size() > 0)
                  if (!rd_q.pop_front()) pull_cnt = (rd_od ? 8 : 60) * CD;
            end
            if (drv) low_len[c]++;
            if (!drv && prev[c] && low_len[c] >= 130 * CD) begin
               since_rel[c] = 0;
               rst_od[c] = (low_len[c] < 500 * CD);
            end else if (since_rel[c] >= 0) begin
               since_rel[c]++;
               if (since_rel[c] > 2000 * CD) since_rel[c] = -1;
            end
            pp = present[c] && since_rel[c] >= 0 &&
                 (rst_od[c] ? (since_rel[c] >= 10 * CD && since_rel[c] < 40 * CD)
                            : (since_rel[c] >= 120 * CD && since_rel[c] < 360 * CD));
            ow_in[c] = !(drv || pp || stuck[c] || (c == rd_ch && pull_cnt > 0));
            prev[c] = drv;
         end
         if (pull_cnt > 0) pull_cnt--;
      end
   end

   // monitor: pad pulse widths, start latency, response contents and timing
   int   acc_e, drv_first, hi_cnt, hi_ch;
   bit   seen_valid;
   exp_t m_e;
   pulse_t m_p;
   always @(negedge clk) begin
      if (!rst_n) begin
         hi_cnt = 0; seen_valid = 0; drv_first = -1;
      end else begin
         if (cmd_valid && cmd_ready) begin
            acc_e = cyc + 1; drv_first = -1; seen_valid = 0;
         end
         if (ow_drive_low != '0) begin
            chk("pad_onehot", 32'($onehot(ow_drive_low)), 1);
            if (drv_first < 0) begin
               drv_first = cyc;
               chk("start_latency", cyc - acc_e, CD);
            end
            if (hi_cnt == 0)
               for (int c = 0; c < N_CH; c++) if (ow_drive_low[c]) hi_ch = c;
            hi_cnt++;
         end else if (hi_cnt > 0) begin
            if (pulse_q.size() == 0) begin
               failures++;
               $display("FAIL pulse_extra actual=%0d cycles required=none", hi_cnt);
            end else begin
               m_p = pulse_q.pop_front();
               chk("pulse_ch", hi_ch, m_p.ch);
               chk("pulse_width", hi_cnt, m_p.ticks * CD);
            end
            hi_cnt = 0;
         end
         if (rsp_valid) begin
            if (exp_q.size() == 0) begin
               failures++;
               $display("FAIL rsp_extra actual=1 required=0");
            end else begin
               m_e = exp_q[0];
               if (!seen_valid) begin
                  seen_valid = 1;
                  if (m_e.err) chk("err_latency", cyc - acc_e, 0);
                  else         chk("rsp_latency", cyc - drv_first, m_e.dur * CD);
               end
               chk("rsp_data", rsp_data, m_e.data);
               chk("rsp_presence", rsp_presence, m_e.pres);
               chk("rsp_err", rsp_err, m_e.err);
               chk("rsp_crc", rsp_crc, m_e.crc);
               chk("cmd_ready_busy", cmd_ready, 0);
               if (rsp_ready) void'(exp_q.pop_front());
            end
         end
      end
   end

   initial begin
      #(300000 * 10);
      $display("FAIL global_timeout actual=running required=finished");
      $fatal(1, "timeout");
   end

   initial begin
      int r, n;
      rst_n = 0; cmd_valid = 0; cmd_op = 0; cmd_len = 0; cmd_data = 0; cmd_ch = 0;
      cmd_od = 0; hold_rdy = 0; model_crc = '0; rd_ch = 0; rd_od = 0;
      checks = 0; failures = 0; cyc = 0;
      repeat (4) @(posedge clk);
      #1 rst_n = 1;
      @(negedge clk);
      chk("rst_rsp_valid", rsp_valid, 0);
      chk("rst_cmd_ready", cmd_ready, 1);
      chk("rst_drive", ow_drive_low, 0);
      chk("rst_crc", rsp_crc, 0);
      chk("rst_data", rsp_data, 0);

      issue(0, 1, 0, 8'h00, 0, 8'h00);     // reset std, device present
      issue(0, 0, 0, 8'h00, 1, 8'h00);     // reset od, no device
      issue(1, 1, 0, 8'h33, 0, 8'h00);     // write 0x33
      issue(2, 1, 0, 8'h00, 0, 8'hA2);     // read 0xA2
      issue(2, 2, 2, 8'h00, 1, 8'h01);     // read 2 bits od: 1,0
      issue(1, N_CH, 3, 8'h55, 0, 8'h00);  // bad channel
      issue(3, 1, 0, 8'h00, 0, 8'h00);     // reserved op

      wait_ready();
      stuck[2] = 1;
      repeat (5) @(negedge clk);
      issue(0, 2, 0, 8'h00, 0, 8'h00);     // bus held low at reset
      wait_ready();
      stuck[2] = 0;
      repeat (5) @(negedge clk);

      hold_rdy = 1;
      issue(1, 2, 3, 8'h05, 1, 8'h00);
      n = 0;
      while (!rsp_valid && n < 20000) begin @(negedge clk); n++; end
      chk("hold_rsp_seen", rsp_valid, 1);
      repeat (50) @(negedge clk);
      hold_rdy = 0;

      for (int k = 0; k < 10; k++) begin
         r = $urandom_range(0, 9);
         if (r < 2)      issue(0, $urandom_range(0, N_CH-1), 0, 8'h00, 1'($urandom_range(0, 1)), 8'h00);
         else if (r < 5) issue(1, $urandom_range(0, N_CH-1), $urandom_range(0, 7), 8'($urandom), 1'($urandom_range(0, 1)), 8'h00);
         else if (r < 8) issue(2, $urandom_range(0, N_CH-1), $urandom_range(0, 7), 8'h00, 1'($urandom_range(0, 1)), 8'($urandom));
         else if (r == 8) issue(3, $urandom_range(0, N_CH-1), 0, 8'h00, 0, 8'h00);
         else            issue($urandom_range(0, 2), 3, 1, 8'h00, 0, 8'h00);
      end

      n = 0;
      while (exp_q.size() != 0 && n < 30000) begin @(negedge clk); n++; end
      chk("rsp_pending", exp_q.size(), 0);
      chk("pulse_pending", pulse_q.size(), 0);

      // reset in the middle of a write-0 slot
      issue(1, 0, 0, 8'h00, 0, 8'h00);
      n = 0;
      while (!ow_drive_low[0] && n < 2000) begin @(negedge clk); n++; end
      chk("midwr_drive_seen", ow_drive_low, 3'b001);
      repeat (10) @(negedge clk);
      #2 rst_n = 0;
      #1 chk("midwr_release", ow_drive_low, 0);
      exp_q.delete(); pulse_q.delete(); rd_q.delete();
      model_crc = '0;
      repeat (3) @(posedge clk);
      #1 rst_n = 1;
      repeat (20) @(negedge clk);
      chk("midwr_no_rsp", rsp_valid, 0);
      chk("midwr_ready", cmd_ready, 1);
      chk("midwr_crc", rsp_crc, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
